multi_clock_divider: RTL and testbench

- Parametrised successor to the fixed four-output divider: NUM_CH independent divider channels from the 40 MHz board clock.
- Each channel has a runtime-programmable half-period, an enable, a square-wave output and a one-cycle tick strobe.
- A valid/ready config port accepts new divisors. A new divisor takes effect only at the channel's next toggle point, so outputs change without glitches.
- Feeds display refresh, scan, blink and debounce logic.

---
 rtl/multi_clock_divider_pkg.sv | 21 ++
 rtl/multi_clock_divider_channel.sv | 85 ++++++++
 rtl/multi_clock_divider.sv | 83 ++++++++
 tb/tb_multi_clock_divider.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_clock_divider_pkg.sv
// Shared constants for multi_clock_divider: counter width, board clock and default half-periods.
package multi_clock_divider_pkg;

    localparam int MCD_CNT_W  = 25;
    localparam int CLK_HZ     = 40_000_000;
    localparam int MCD_NUM_CH = 4;

    // Half-period in clk cycles = CLK_HZ / (2 * f_out)
    localparam logic [MCD_CNT_W-1:0] HALF_1HZ   = MCD_CNT_W'(CLK_HZ / 2);
    localparam logic [MCD_CNT_W-1:0] HALF_3HZ   = MCD_CNT_W'(CLK_HZ / 6);
    localparam logic [MCD_CNT_W-1:0] HALF_6HZ   = MCD_CNT_W'(CLK_HZ / 12);
    localparam logic [MCD_CNT_W-1:0] HALF_100HZ = MCD_CNT_W'(CLK_HZ / 200);

    localparam logic [MCD_NUM_CH*MCD_CNT_W-1:0] MCD_DEF_HALF =
        {HALF_3HZ, HALF_6HZ, HALF_100HZ, HALF_1HZ};

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: counter, active/next half-period and glitch-free divisor swap
// at the toggle point, plus registered square wave and rising-edge tick.
module mcd_channel
    import multi_clock_divider_pkg::*;
#(
    parameter int               CNT_W    = MCD_CNT_W,
    parameter logic [CNT_W-1:0] RST_HALF = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_half,
    input  logic             sync,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] nxt_half_q, nxt_half_d;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             at_top;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        cnt_d      = cnt_q;
        half_d     = half_q;
        nxt_half_d = nxt_half_q;
        pending_d  = pending_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        at_top     = (cnt_q == half_q - ONE);

        if (sync || !en) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (at_top) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = ~clk_out_q;
        end else begin
            cnt_d     = cnt_q + ONE;
        end

        // Accept only happens while nothing is pending, so apply and load never collide.
        if (pending_q && (sync || !en || at_top)) begin
            half_d    = nxt_half_q;
            pending_d = 1'b0;
        end
        if (load) begin
            nxt_half_d = load_half;
            pending_d  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            half_q     <= RST_HALF;
            nxt_half_q <= RST_HALF;
            pending_q  <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            nxt_half_q <= nxt_half_d;
            pending_q  <= pending_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign pending = pending_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH programmable clock divider with valid/ready divisor config port.
// Define MULTI_CLOCK_DIVIDER_SYNC_EN to add a 'sync' input that phase-aligns all channels.
module multi_clock_divider
    import multi_clock_divider_pkg::*;
#(
    parameter int                      NUM_CH   = MCD_NUM_CH,
    parameter int                      CNT_W    = MCD_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_HALF = MCD_DEF_HALF,
    localparam int                     CH_W     = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    input  logic              sync,
`endif
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam int              PAD_CH   = 1 << CH_W;
    localparam logic [CH_W:0]   NUM_CH_V = NUM_CH[CH_W:0];

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] load;
    logic [PAD_CH-1:0] pending_pad;
    logic              ch_ok, half_ok, accept;
    logic              cfg_err_q, cfg_err_d;
    logic              sync_all;

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    assign sync_all = sync;
`else
    assign sync_all = 1'b0;
`endif

    always_comb begin
        // Padding keeps the pending lookup in range for non power-of-two NUM_CH.
        pending_pad               = '0;
        pending_pad[NUM_CH-1:0]   = pending;
        ch_ok     = ({1'b0, cfg_ch} < NUM_CH_V);
        half_ok   = (cfg_half != '0);
        cfg_ready = ch_ok ? ~pending_pad[cfg_ch] : 1'b1;
        accept    = cfg_valid && cfg_ready;
        cfg_err_d = accept && !(ch_ok && half_ok);
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = accept && ch_ok && half_ok && (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mcd_channel #(
            .CNT_W    (CNT_W),
            .RST_HALF (DEF_HALF[g*CNT_W +: CNT_W])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (en[g]),
            .load      (load[g]),
            .load_half (cfg_half),
            .sync      (sync_all),
            .pending   (pending[g]),
            .clk_out   (clk_out[g]),
            .tick      (tick[g])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: 3 channels, 8-bit counters, defaults {4,5,3}.
module tb_multi_clock_divider;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              cfg_valid;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic              cfg_ready;
    logic              cfg_err;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    logic              sync;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    multi_clock_divider #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DEF_HALF ({8'd4, 8'd5, 8'd3})
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
        .sync      (sync),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [2:0] en;
        logic [2:0] exp_clk;
        logic [2:0] exp_tick;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called just after a clock edge; the next edge is the first one out of reset.
    task automatic do_reset();
        cfg_valid = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        // Expected {ch2,ch1,ch0} after each edge with ch0 half=3, ch1 half=5, ch2 off.
        vecs[0]  = '{3'b011, 3'b000, 3'b000};
        vecs[1]  = '{3'b011, 3'b000, 3'b000};
        vecs[2]  = '{3'b011, 3'b001, 3'b001};
        vecs[3]  = '{3'b011, 3'b001, 3'b000};
        vecs[4]  = '{3'b011, 3'b011, 3'b010};
        vecs[5]  = '{3'b011, 3'b010, 3'b000};
        vecs[6]  = '{3'b011, 3'b010, 3'b000};
        vecs[7]  = '{3'b011, 3'b010, 3'b000};
        vecs[8]  = '{3'b011, 3'b011, 3'b001};
        vecs[9]  = '{3'b011, 3'b001, 3'b000};
        vecs[10] = '{3'b011, 3'b001, 3'b000};
        vecs[11] = '{3'b011, 3'b000, 3'b000};
        vecs[12] = '{3'b011, 3'b000, 3'b000};
        vecs[13] = '{3'b011, 3'b000, 3'b000};
        vecs[14] = '{3'b011, 3'b011, 3'b011};
        vecs[15] = '{3'b011, 3'b011, 3'b000};

        rst       = 1'b0;
        en        = 3'b011;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_half  = '0;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
        sync      = 1'b0;
`endif

        // Reset holds everything low even with enables asserted and clocks running.
        #12;
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_cfg_err", cfg_err, 0);
        step();
        check("rst_clk_out_clocked", clk_out, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        rst = 1'b1;

        // Default periods from the table.
        for (int i = 0; i < 16; i++) begin
            en = vecs[i].en;
            step();
            check($sformatf("vec%0d_clk_out", i), clk_out, vecs[i].exp_clk);
            check($sformatf("vec%0d_tick", i), tick, vecs[i].exp_tick);
        end

        // Reconfigure ch0 3 -> 2 mid-period; second write blocked while pending.
        en = 3'b001;
        do_reset();
        step();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd2;
        check("recfg_ready_idle", cfg_ready, 1);
        step();
        cfg_half = 8'd7;
        check("recfg_ready_pending", cfg_ready, 0);
        check("recfg_e2_clk", clk_out[0], 0);
        step();
        check("recfg_e3_clk", clk_out[0], 1);
        check("recfg_e3_tick", tick[0], 1);
        check("recfg_ready_applied", cfg_ready, 1);
        cfg_valid = 1'b0;
        step();
        check("recfg_e4_clk", clk_out[0], 1);
        step();
        check("recfg_e5_clk", clk_out[0], 0);
        step();
        check("recfg_e6_clk", clk_out[0], 0);
        step();
        check("recfg_e7_clk", clk_out[0], 1);
        check("recfg_e7_tick", tick[0], 1);
        step();
        check("recfg_e8_tick", tick[0], 0);

        // Rejected writes: zero half-period, then out-of-range channel.
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd0;
        check("err_zero_ready", cfg_ready, 1);
        step();
        check("err_zero_pulse", cfg_err, 1);
        check("err_zero_e9_clk", clk_out[0], 0);
        cfg_valid = 1'b0;
        step();
        check("err_zero_clear", cfg_err, 0);
        step();
        check("err_zero_period_clk", clk_out[0], 1);
        check("err_zero_period_tick", tick[0], 1);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd5;
        check("err_ch_ready", cfg_ready, 1);
        step();
        check("err_ch_pulse", cfg_err, 1);
        cfg_valid = 1'b0;
        step();
        check("err_ch_clear", cfg_err, 0);
        check("err_ch_e13_clk", clk_out[0], 0);
        step();
        step();
        check("err_ch_period_tick", tick[0], 1);

        // Enable gating on ch1 (half=5).
        en = 3'b010;
        do_reset();
        repeat (5) step();
        check("gate_first_rise", clk_out[1], 1);
        check("gate_first_tick", tick[1], 1);
        step();
        check("gate_high", clk_out[1], 1);
        en = 3'b000;
        step();
        check("gate_drop_clk", clk_out[1], 0);
        check("gate_drop_tick", tick[1], 0);
        en = 3'b010;
        repeat (4) step();
        check("gate_reen_e4", clk_out[1], 0);
        step();
        check("gate_reen_rise", clk_out[1], 1);
        check("gate_reen_tick", tick[1], 1);
        en = 3'b000;
        step();
        check("gate_off_again", clk_out[1], 0);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd2;
        step();
        check("gate_pending_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        step();
        check("gate_applied_ready", cfg_ready, 1);
        en = 3'b010;
        step();
        check("gate_new_e1", clk_out[1], 0);
        step();
        check("gate_new_rise", clk_out[1], 1);
        check("gate_new_tick", tick[1], 1);

        // Async reset mid-run discards a pending write.
        en = 3'b011;
        do_reset();
        repeat (3) step();
        check("arst_pre_clk", clk_out[0], 1);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd7;
        step();
        check("arst_pending_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_clk_out_clear", clk_out, 0);
        check("arst_ready", cfg_ready, 1);
        #1;
        rst = 1'b1;
        repeat (3) step();
        check("arst_def_rise", clk_out[0], 1);
        check("arst_def_tick", tick[0], 1);
        repeat (2) step();
        check("arst_ch1_rise", clk_out[1], 1);
        step();
        check("arst_def_fall", clk_out[0], 0);
        repeat (3) step();
        check("arst_def_period", tick[0], 1);

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
        // Skew ch0 and ch2 (both half=4), then align them with one sync pulse.
        en = 3'b000;
        do_reset();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd4;
        step();
        cfg_valid = 1'b0;
        step();
        en = 3'b100;
        step();
        en = 3'b101;
        repeat (3) step();
        check("sync_skewed", clk_out, 3'b100);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_cleared", clk_out, 3'b000);
        repeat (3) step();
        check("sync_still_low", clk_out, 3'b000);
        step();
        check("sync_aligned_clk", clk_out, 3'b101);
        check("sync_aligned_tick", tick, 3'b101);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
